nes_poll_scheduler: RTL and testbench

- Sequences the NES pad serial interface: generates a periodic latch pulse and 7 shift-clock pulses, and samples two pads that share one latch/clock pair (player 0 on d0, player 1 on d1).
- Deserialises each pad into an active-high 8-bit button vector and flags newly pressed buttons.
- Sits between the pad pins and game logic, replacing free-running per-pad drivers with a single scheduler for both pads.

---
 rtl/nes_poll_scheduler.sv | 159 +++++++++++++++
 tb/tb_nes_poll_scheduler.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nes_poll_scheduler.sv
// Dual NES pad poller: one shared latch/clock pair, two serial data lines,
// deserialised into active-high button vectors with newly-pressed flags.
module nes_poll_scheduler #(
    parameter int unsigned POLL_CYCLES  = 833333,
    parameter int unsigned LATCH_CYCLES = 600,
    parameter int unsigned HALF_CYCLES  = 300
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       d0,
    input  logic       d1,
    output logic       nes_latch,
    output logic       nes_clk,
    output logic [7:0] p0_buttons,
    output logic [7:0] p1_buttons,
    output logic [7:0] p0_pressed,
    output logic [7:0] p1_pressed,
    output logic       valid,
    output logic       busy
);
    // state | meaning: IDLE wait for start | LATCH latch pulse | LOW clk low, sample at end
    //                  HIGH clk high, advance bit | DONE publish vectors
    typedef enum logic [2:0] {S_IDLE, S_LATCH, S_LOW, S_HIGH, S_DONE} state_t;

    localparam int unsigned PW     = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int unsigned PH_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
    localparam int unsigned CW     = $clog2(PH_MAX);

    localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_CYCLES - 1);
    localparam logic [CW-1:0] LATCH_LOAD = CW'(LATCH_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LOAD  = CW'(HALF_CYCLES - 1);

    state_t          state_q, state_d;
    logic [PW-1:0]   poll_q;
    logic [CW-1:0]   phase_q, phase_d;
    logic [2:0]      bit_q, bit_d;
    logic [1:0]      meta_q, sync_q;
    logic [7:0]      shift0_q, shift1_q;
    logic [7:0]      p0_buttons_q, p1_buttons_q, p0_pressed_q, p1_pressed_q;
    logic            latch_q, nclk_q, valid_q, busy_q;
    logic            start;
    logic            sample;

    assign start = en && (poll_q == '0) && (state_q == S_IDLE);

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        sample  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LATCH;
                    phase_d = LATCH_LOAD;
                    bit_d   = 3'd0;
                end
            end
            S_LATCH: begin
                if (phase_q == '0) begin
                    state_d = S_LOW;
                    phase_d = HALF_LOAD;
                end else begin
                    phase_d = phase_q - 1'b1;
                end
            end
            S_LOW: begin
                if (phase_q == '0) begin
                    sample = 1'b1;
                    if (bit_q == 3'd7) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_HIGH;
                        phase_d = HALF_LOAD;
                    end
                end else begin
                    phase_d = phase_q - 1'b1;
                end
            end
            S_HIGH: begin
                if (phase_q == '0) begin
                    state_d = S_LOW;
                    phase_d = HALF_LOAD;
                    bit_d   = bit_q + 3'd1;
                end else begin
                    phase_d = phase_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            poll_q       <= '0;
            phase_q      <= '0;
            bit_q        <= 3'd0;
            meta_q       <= 2'b00;
            sync_q       <= 2'b00;
            shift0_q     <= 8'h00;
            shift1_q     <= 8'h00;
            p0_buttons_q <= 8'h00;
            p1_buttons_q <= 8'h00;
            p0_pressed_q <= 8'h00;
            p1_pressed_q <= 8'h00;
            latch_q      <= 1'b0;
            nclk_q       <= 1'b0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            meta_q  <= {d1, d0};
            sync_q  <= meta_q;

            if (!en || poll_q == POLL_LAST) begin
                poll_q <= '0;
            end else begin
                poll_q <= poll_q + 1'b1;
            end

            // Pad data is active-low; store pressed as 1.
            if (sample) begin
                shift0_q[bit_q] <= ~sync_q[0];
                shift1_q[bit_q] <= ~sync_q[1];
            end

            if (state_q == S_DONE) begin
                p0_buttons_q <= shift0_q;
                p1_buttons_q <= shift1_q;
                p0_pressed_q <= shift0_q & ~p0_buttons_q;
                p1_pressed_q <= shift1_q & ~p1_buttons_q;
            end

            latch_q <= (state_d == S_LATCH);
            nclk_q  <= (state_d == S_HIGH);
            valid_q <= (state_q == S_DONE);
            busy_q  <= (state_d != S_IDLE);
        end
    end

    assign nes_latch  = latch_q;
    assign nes_clk    = nclk_q;
    assign valid      = valid_q;
    assign busy       = busy_q;
    assign p0_buttons = p0_buttons_q;
    assign p1_buttons = p1_buttons_q;
    assign p0_pressed = p0_pressed_q;
    assign p1_pressed = p1_pressed_q;

endmodule

// File: tb/tb_nes_poll_scheduler.sv
// Bench for nes_poll_scheduler: pad model on the shared latch/clock, table
// vectors for edge detection, random vectors against a button-history model.
module tb_nes_poll_scheduler;
    localparam int POLL = 200;
    localparam int LAT  = 6;
    localparam int HALF = 4;
    localparam int POLL_LEN = LAT + 15 * HALF + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b1;
    logic       d0, d1;
    logic       nes_latch, nes_clk, valid, busy;
    logic [7:0] p0_buttons, p1_buttons, p0_pressed, p1_pressed;

    logic [7:0] pad0 = 8'h00;
    logic [7:0] pad1 = 8'h00;
    int         pad_idx = 0;
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    logic [7:0] mb0 = 8'h00;
    logic [7:0] mb1 = 8'h00;

    typedef struct {
        logic [7:0] in0;
        logic [7:0] in1;
        logic [7:0] b0;
        logic [7:0] pr0;
        logic [7:0] b1;
        logic [7:0] pr1;
    } vec_t;
    vec_t tbl[4];

    nes_poll_scheduler #(
        .POLL_CYCLES (POLL),
        .LATCH_CYCLES(LAT),
        .HALF_CYCLES (HALF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .d0        (d0),
        .d1        (d1),
        .nes_latch (nes_latch),
        .nes_clk   (nes_clk),
        .p0_buttons(p0_buttons),
        .p1_buttons(p1_buttons),
        .p0_pressed(p0_pressed),
        .p1_pressed(p1_pressed),
        .valid     (valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pad: latch reloads bit 0 (A), each clock rise presents the next bit.
    always @(posedge nes_latch or posedge nes_clk) begin
        if (nes_latch) pad_idx = 0;
        else if (pad_idx < 8) pad_idx = pad_idx + 1;
    end
    assign d0 = (pad_idx < 8) ? ~pad0[pad_idx[2:0]] : 1'b1;
    assign d1 = (pad_idx < 8) ? ~pad1[pad_idx[2:0]] : 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_latch(input int budget, output int elapsed);
        elapsed = 0;
        while (!nes_latch && elapsed < budget) begin
            @(negedge clk);
            elapsed++;
        end
        check("latch_wait", {31'd0, nes_latch}, 32'd1);
    endtask

    // Called at the first negedge where nes_latch is high; observes 80 cycles.
    task automatic check_poll();
        int lat_w, nrise, min_hi, max_hi, valid_at, valid_n, busy_n, both_hi, run;
        logic prev_clk;
        lat_w = 0; nrise = 0; min_hi = 999; max_hi = 0; valid_at = -1;
        valid_n = 0; busy_n = 0; both_hi = 0; run = 0; prev_clk = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (nes_latch) lat_w++;
            if (nes_clk) begin
                if (!prev_clk) nrise++;
                run++;
            end else if (prev_clk) begin
                if (run < min_hi) min_hi = run;
                if (run > max_hi) max_hi = run;
                run = 0;
            end
            if (valid) begin
                valid_n++;
                if (valid_at < 0) valid_at = i;
            end
            if (busy) busy_n++;
            if (nes_latch && nes_clk) both_hi++;
            prev_clk = nes_clk;
            @(negedge clk);
        end
        check("latch_width", lat_w, LAT);
        check("clk_rises", nrise, 7);
        check("clk_high_min", min_hi, HALF);
        check("clk_high_max", max_hi, HALF);
        check("valid_offset", valid_at, POLL_LEN);
        check("valid_count", valid_n, 1);
        check("busy_cycles", busy_n, POLL_LEN);
        check("latch_clk_overlap", both_hi, 0);
    endtask

    task automatic check_out(input logic [7:0] b0, input logic [7:0] pr0,
                             input logic [7:0] b1, input logic [7:0] pr1);
        check("p0_buttons", p0_buttons, b0);
        check("p0_pressed", p0_pressed, pr0);
        check("p1_buttons", p1_buttons, b1);
        check("p1_pressed", p1_pressed, pr1);
    endtask

    // Model-based check: pressed = new buttons not held at the previous update.
    task automatic check_model(input logic [7:0] n0, input logic [7:0] n1);
        check_out(n0, n0 & ~mb0, n1, n1 & ~mb1);
        mb0 = n0;
        mb1 = n1;
    endtask

    task automatic wait_clk_rises(input int target, input int budget);
        int   seen, n;
        logic prev;
        seen = 0; n = 0; prev = nes_clk;
        while (seen < target && n < budget) begin
            @(negedge clk);
            n++;
            if (nes_clk && !prev) seen++;
            prev = nes_clk;
        end
        check("clk_rise_wait", seen, target);
    endtask

    initial begin
        int         el, last_rise, act;
        logic [7:0] n0, n1;

        tbl[0] = '{8'h81, 8'h10, 8'h81, 8'h81, 8'h10, 8'h10};
        tbl[1] = '{8'h81, 8'h10, 8'h81, 8'h00, 8'h10, 8'h00};
        tbl[2] = '{8'h01, 8'h30, 8'h01, 8'h00, 8'h30, 8'h20};
        tbl[3] = '{8'h03, 8'h21, 8'h03, 8'h02, 8'h21, 8'h01};

        // Reset held with en=1: no activity, all outputs zero.
        reset = 1'b1;
        en    = 1'b1;
        pad0  = tbl[0].in0;
        pad1  = tbl[0].in1;
        act   = 0;
        repeat (5) begin
            @(negedge clk);
            if (nes_latch || nes_clk || valid || busy) act++;
        end
        check("reset_activity", act, 0);
        check_out(8'h00, 8'h00, 8'h00, 8'h00);

        reset = 1'b0;
        wait_latch(250, el);
        check("start_after_reset", el, 1);

        // Table: first poll plus edge detection across successive polls.
        last_rise = 0;
        for (int r = 0; r < 4; r++) begin
            if (r > 0) begin
                pad0 = tbl[r].in0;
                pad1 = tbl[r].in1;
                wait_latch(250, el);
                check("latch_period", cyc - last_rise, POLL);
            end
            last_rise = cyc;
            check_poll();
            check_out(tbl[r].b0, tbl[r].pr0, tbl[r].b1, tbl[r].pr1);
            mb0 = tbl[r].b0;
            mb1 = tbl[r].b1;
        end

        // Random vectors against the history model.
        for (int k = 0; k < 10; k++) begin
            n0 = 8'($urandom_range(0, 255));
            n1 = 8'($urandom_range(0, 255));
            pad0 = n0;
            pad1 = n1;
            wait_latch(250, el);
            check("latch_period", cyc - last_rise, POLL);
            last_rise = cyc;
            check_poll();
            check_model(n0, n1);
        end

        // Enable dropped after the 3rd clock rise: poll still completes.
        n0 = 8'($urandom_range(0, 255));
        n1 = 8'($urandom_range(0, 255));
        pad0 = n0;
        pad1 = n1;
        wait_latch(250, el);
        wait_clk_rises(3, 100);
        en = 1'b0;
        act = 0;
        for (int i = 0; i < 100 && act == 0; i++) begin
            @(negedge clk);
            if (valid) act = 1;
        end
        check("valid_after_en_drop", act, 1);
        @(negedge clk);
        check_model(n0, n1);
        act = 0;
        repeat (400) begin
            @(negedge clk);
            if (nes_latch || busy) act++;
        end
        check("idle_while_disabled", act, 0);
        en = 1'b1;
        @(negedge clk);
        check("latch_on_enable", {31'd0, nes_latch}, 32'd1);
        last_rise = cyc;
        check_poll();
        check_model(n0, n1);

        // Reset during the 4th HIGH phase aborts the poll without valid.
        pad0 = 8'($urandom_range(0, 255));
        pad1 = 8'h00;
        wait_latch(250, el);
        check("latch_period", cyc - last_rise, POLL);
        wait_clk_rises(4, 100);
        reset = 1'b1;
        #1;
        check("abort_latch", {31'd0, nes_latch}, 32'd0);
        check("abort_clk", {31'd0, nes_clk}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check_out(8'h00, 8'h00, 8'h00, 8'h00);
        mb0 = 8'h00;
        mb1 = 8'h00;
        act = 0;
        repeat (3) begin
            @(negedge clk);
            if (valid) act++;
        end
        check("abort_no_valid", act, 0);
        n0 = 8'($urandom_range(0, 255));
        n1 = 8'hFF;
        pad0 = n0;
        pad1 = n1;
        reset = 1'b0;
        wait_latch(250, el);
        check("restart_after_abort", el, 1);
        check_poll();
        check_out(n0, n0, 8'hFF, 8'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
